wts_key_event_scheduler: RTL

Converts a serial key-command stream (one command per accepted handshake) into the per-channel one-cycle `ch_*_key_on` / `ch_*_key_release` / `ch_*_key_off` pulses consumed by `wts_adsr_envelope_generator_5ch`. Each channel holds at most one pending event, which is released only in that channel's time slot of the shared `active` scan, so pulses are slot-aligned with the envelope generator. A per-channel state machine suppresses illegal releases and reports which channels are sounding.

---
 rtl/wts_key_event_scheduler.sv | 106 ++++++++++
 1 files changed

// File: rtl/wts_key_event_scheduler.sv
// wts_key_event_scheduler: slot-aligned key command to per-channel pulse scheduler (optional WTS_KEY_RETRIGGER_OFF_EN)
module wts_key_event_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] active,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_channel,
  input  logic [1:0] cmd_type,
  output logic       ch_a_key_on,
  output logic       ch_a_key_release,
  output logic       ch_a_key_off,
  output logic       ch_b_key_on,
  output logic       ch_b_key_release,
  output logic       ch_b_key_off,
  output logic       ch_c_key_on,
  output logic       ch_c_key_release,
  output logic       ch_c_key_off,
  output logic       ch_d_key_on,
  output logic       ch_d_key_release,
  output logic       ch_d_key_off,
  output logic       ch_e_key_on,
  output logic       ch_e_key_release,
  output logic       ch_e_key_off,
  output logic [4:0] key_status
);
  typedef enum logic [1:0] {IDLE, ON, RELEASED} state_t;
  state_t     st [5];
  state_t     st_n [5];
  logic [1:0] pt [5];
  logic [1:0] pt_n [5];
  logic [4:0] pv, pv_n;
  logic [4:0] on_q, rel_q, off_q, on_n, rel_n, off_n;
  logic [7:0] pv8;
  logic       store, go;
  assign pv8 = {3'b000, pv};
  assign cmd_ready = cmd_channel > 3'd4 || cmd_type == 2'd2 || !pv8[cmd_channel];
  assign store = cmd_valid && cmd_ready && cmd_channel < 3'd5 && cmd_type != 2'd3;
  // Dispatch the slot's pending event; a same-channel key_off accept takes priority over dispatch
  always_comb begin
    st_n = st;
    pt_n = pt;
    pv_n = pv;
    on_n = '0;
    rel_n = '0;
    off_n = '0;
    go = 1'b0;
    for (int i = 0; i < 5; i++) begin
      go = active == 3'(i) && pv[i] && !(store && cmd_channel == 3'(i));
      if (go) begin
        if (pt[i] == 2'd0) begin
`ifdef WTS_KEY_RETRIGGER_OFF_EN
          if (st[i] != IDLE) begin
            off_n[i] = 1'b1;
            st_n[i] = IDLE;
          end else begin
            on_n[i] = 1'b1;
            st_n[i] = ON;
            pv_n[i] = 1'b0;
          end
`else
          on_n[i] = 1'b1;
          st_n[i] = ON;
          pv_n[i] = 1'b0;
`endif
        end else if (pt[i] == 2'd1) begin
          pv_n[i] = 1'b0;
          rel_n[i] = st[i] == ON;
          st_n[i] = st[i] == ON ? RELEASED : st[i];
        end else begin
          pv_n[i] = 1'b0;
          off_n[i] = 1'b1;
          st_n[i] = IDLE;
        end
      end
      if (store && cmd_channel == 3'(i)) begin
        pv_n[i] = 1'b1;
        pt_n[i] = cmd_type;
      end
    end
  end
  // Channel state, pending slots and registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        st[i] <= IDLE;
        pt[i] <= 2'd0;
      end
      pv <= '0;
      on_q <= '0;
      rel_q <= '0;
      off_q <= '0;
    end else begin
      st <= st_n;
      pt <= pt_n;
      pv <= pv_n;
      on_q <= on_n;
      rel_q <= rel_n;
      off_q <= off_n;
    end
  end
  always_comb for (int i = 0; i < 5; i++) key_status[i] = st[i] != IDLE;
  assign {ch_e_key_on, ch_d_key_on, ch_c_key_on, ch_b_key_on, ch_a_key_on} = on_q;
  assign {ch_e_key_release, ch_d_key_release, ch_c_key_release, ch_b_key_release, ch_a_key_release} = rel_q;
  assign {ch_e_key_off, ch_d_key_off, ch_c_key_off, ch_b_key_off, ch_a_key_off} = off_q;
endmodule
